// File: rtl/sopc_v3_onchip_mem_arbiter.sv
// sopc_v3_onchip_mem_arbiter: two-master round-robin front end for the
// single-port on-chip RAM (1-cycle read latency), with range blocking
// and a drain/halt handshake ahead of RAM clken/reset_req gating.
// Ports:
//   clk, reset         : single clock, synchronous active-high reset
//   m0_*, m1_*         : Avalon-MM slave ports (m0 = CPU data, m1 = DMA)
//   halt_req, halt_ack : quiesce request (level) / idle-and-gated status
//   mem_*              : RAM side; mem_readdata valid cycle after issue
module sopc_v3_onchip_mem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int NUM_WORDS = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_err,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // A depth covering the whole address space has no out-of-range words.
  localparam bit FULL_MAP =
    longint'(NUM_WORDS) >= (longint'(1) << ADDR_W);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_WORDS);

  state_t state;
  logic   rr_ptr;
  logic   tag_valid;
  logic   tag_id;
  logic   tag_oor;
  logic   err0_q;
  logic   err1_q;
  logic   halt_ack_q;
  logic   clken_q;
  logic   rst_req_q;

  logic              req0;
  logic              req1;
  logic              can_grant;
  logic              grant0;
  logic              grant1;
  logic              acc;
  logic              contended;
  logic              sel_wr;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign can_grant = ~reset & (state == RUN) & ~halt_req;

  // rr_ptr only breaks ties; a lone requester always wins.
  assign grant0 = can_grant & req0 & (~req1 | ~rr_ptr);
  assign grant1 = can_grant & req1 & (~req0 | rr_ptr);
  assign acc = grant0 | grant1;
  assign contended = req0 & req1 & acc;

  assign sel_addr = grant1 ? m1_address : m0_address;
  assign sel_wr = grant1 ? m1_write : m0_write;
  assign sel_oor = ~FULL_MAP & (sel_addr >= LIMIT);

  assign mem_address = sel_addr;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata = grant1 ? m1_writedata : m0_writedata;
  assign mem_chipselect = acc & ~sel_oor;
  assign mem_write = mem_chipselect & sel_wr;

  assign m0_waitrequest = reset | (state != RUN) | (req0 & ~grant0);
  assign m1_waitrequest = reset | (state != RUN) | (req1 & ~grant1);

  assign m0_readdatavalid = tag_valid & ~tag_id;
  assign m1_readdatavalid = tag_valid & tag_id;

  // Out-of-range reads return zero instead of stale RAM output.
  assign m0_readdata = (m0_readdatavalid & ~tag_oor) ?
                       mem_readdata : '0;
  assign m1_readdata = (m1_readdatavalid & ~tag_oor) ?
                       mem_readdata : '0;

  assign m0_err = err0_q;
  assign m1_err = err1_q;

  assign halt_ack = halt_ack_q;
  assign mem_clken = clken_q;
  assign mem_reset_req = rst_req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      rr_ptr     <= 1'b0;
      tag_valid  <= 1'b0;
      tag_id     <= 1'b0;
      tag_oor    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      halt_ack_q <= 1'b0;
      clken_q    <= 1'b1;
      rst_req_q  <= 1'b0;
    end else begin
      tag_valid <= acc & ~sel_wr;
      tag_id    <= grant1;
      tag_oor   <= sel_oor;
      err0_q    <= grant0 & sel_oor;
      err1_q    <= grant1 & sel_oor;
      // Winner of a tie hands priority to the other master.
      if (contended) rr_ptr <= grant0;
      unique case (state)
        RUN: begin
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!tag_valid) begin
            state      <= HALTED;
            halt_ack_q <= 1'b1;
            clken_q    <= 1'b0;
            rst_req_q  <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state      <= RUN;
            halt_ack_q <= 1'b0;
            clken_q    <= 1'b1;
            rst_req_q  <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          halt_ack_q <= 1'b0;
          clken_q    <= 1'b1;
          rst_req_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_v3_onchip_mem_arbiter.sv
// tb_sopc_v3_onchip_mem_arbiter: directed and randomized bench for the
// two-master on-chip RAM arbiter, with a RAM model and golden memory.
module tb_sopc_v3_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic        m0_err;
  logic [12:0] m1_address;
  logic [3:0]  m1_byteenable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic        m1_err;
  logic        halt_req;
  logic        halt_ack;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        mem_reset_req;
  logic [31:0] mem_readdata;

  int passed = 0;
  int total = 0;
  int pref = 0;

  logic [31:0] ram  [0:8191];
  logic [31:0] gold [0:8191];
  logic [31:0] ram_q = '0;

  always #5 clk = ~clk;

  sopc_v3_onchip_mem_arbiter dut (
    .clk(clk),
    .reset(reset),
    .m0_address(m0_address),
    .m0_byteenable(m0_byteenable),
    .m0_read(m0_read),
    .m0_write(m0_write),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m0_err(m0_err),
    .m1_address(m1_address),
    .m1_byteenable(m1_byteenable),
    .m1_read(m1_read),
    .m1_write(m1_write),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .m1_err(m1_err),
    .halt_req(halt_req),
    .halt_ack(halt_ack),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req),
    .mem_readdata(mem_readdata)
  );

  // Single-port RAM with registered read data.
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic in_range(input logic [12:0] a);
    return int'(a) < 5000;
  endfunction

  function automatic logic [12:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 13'(256 + $urandom_range(0, 15));
    if (r == 6) return 13'($urandom_range(4998, 5001));
    if (r == 7) return 13'($urandom_range(5000, 8191));
    if (r == 8) return 13'd8191;
    return 13'($urandom_range(0, 4999));
  endfunction

  task automatic bus_idle();
    m0_read = 0; m0_write = 0; m0_address = '0;
    m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0;
    m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic test_reset();
    bus_idle();
    halt_req = 0;
    reset = 1;
    m0_read = 1;
    m0_address = 13'h010;
    repeat (3) begin
      @(negedge clk);
      total++; if (m0_waitrequest !== 1'b1)
        $display("FAIL rst_wait0 got %b exp 1", m0_waitrequest);
      else passed++;
      total++; if (mem_chipselect !== 1'b0)
        $display("FAIL rst_cs got %b exp 0", mem_chipselect);
      else passed++;
      total++; if (m0_readdatavalid !== 1'b0)
        $display("FAIL rst_valid got %b exp 0", m0_readdatavalid);
      else passed++;
    end
    total++; if (m1_waitrequest !== 1'b1)
      $display("FAIL rst_wait1 got %b exp 1", m1_waitrequest);
    else passed++;
    total++;
    if ({halt_ack, mem_clken, mem_reset_req, m0_err} !== 4'b0100)
      $display("FAIL rst_ctl got %b exp 0100",
               {halt_ack, mem_clken, mem_reset_req, m0_err});
    else passed++;
    total++; if (m0_readdata !== 32'h0)
      $display("FAIL rst_rdata got %h exp 0", m0_readdata);
    else passed++;
    bus_idle();
    reset = 0;
    pref = 0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    m0_write = 1; m0_address = 13'h010;
    m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
    #1;
    total++;
    if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b011)
      $display("FAIL wr_issue got %b exp 011",
               {m0_waitrequest, mem_chipselect, mem_write});
    else passed++;
    total++; if (mem_address !== 13'h010)
      $display("FAIL wr_addr got %h exp 010", mem_address);
    else passed++;
    gold[16] = merge(gold[16], 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    total++; if ({m0_readdatavalid, m0_err} !== 2'b00)
      $display("FAIL wr_noresp got %b exp 00",
               {m0_readdatavalid, m0_err});
    else passed++;
    m0_write = 0; m0_read = 1;
    #1;
    total++;
    if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b010)
      $display("FAIL rd_issue got %b exp 010",
               {m0_waitrequest, mem_chipselect, mem_write});
    else passed++;
    @(negedge clk);
    m0_read = 0;
    total++; if (m0_readdatavalid !== 1'b1)
      $display("FAIL rd_valid got %b exp 1", m0_readdatavalid);
    else passed++;
    total++; if (m0_readdata !== 32'hDEADBEEF)
      $display("FAIL rd_data got %h exp deadbeef", m0_readdata);
    else passed++;
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b0)
      $display("FAIL rd_pulse got %b exp 0", m0_readdatavalid);
    else passed++;
    bus_idle();
  endtask

  task automatic test_round_robin();
    logic [12:0] na0;
    logic [12:0] na1;
    logic [12:0] ea;
    logic [31:0] ed;
    int ew;
    na0 = 13'h040; na1 = 13'h050;
    m0_read = 1; m1_read = 1;
    for (int k = 0; k < 6; k++) begin
      m0_address = na0; m1_address = na1;
      #1;
      ew = k % 2;
      ea = (ew == 0) ? na0 : na1;
      ed = gold[ea];
      total++;
      if ({m0_waitrequest, m1_waitrequest} !==
          {ew != 0, ew == 0})
        $display("FAIL rr_grant k=%0d got %b%b exp m%0d", k,
                 m0_waitrequest, m1_waitrequest, ew);
      else passed++;
      total++; if (mem_address !== ea)
        $display("FAIL rr_addr k=%0d got %h exp %h",
                 k, mem_address, ea);
      else passed++;
      @(negedge clk);
      total++;
      if ({m0_readdatavalid, m1_readdatavalid} !==
          {ew == 0, ew != 0})
        $display("FAIL rr_valid k=%0d got %b%b exp m%0d", k,
                 m0_readdatavalid, m1_readdatavalid, ew);
      else passed++;
      total++;
      if (((ew == 0) ? m0_readdata : m1_readdata) !== ed)
        $display("FAIL rr_data k=%0d got %h exp %h", k,
                 (ew == 0) ? m0_readdata : m1_readdata, ed);
      else passed++;
      if (ew == 0) na0 = na0 + 13'd1;
      else na1 = na1 + 13'd1;
    end
    pref = 0;
    bus_idle();
  endtask

  task automatic test_out_of_range();
    m1_write = 1; m1_address = 13'd5000;
    m1_writedata = 32'h12345678;
    #1;
    total++;
    if ({m1_waitrequest, mem_chipselect, mem_write} !== 3'b000)
      $display("FAIL oor_wr got %b exp 000",
               {m1_waitrequest, mem_chipselect, mem_write});
    else passed++;
    @(negedge clk);
    total++; if ({m1_err, m1_readdatavalid} !== 2'b10)
      $display("FAIL oor_wr_err got %b exp 10",
               {m1_err, m1_readdatavalid});
    else passed++;
    m1_write = 0; m1_read = 1; m1_address = 13'd8191;
    #1;
    total++; if ({m1_waitrequest, mem_chipselect} !== 2'b00)
      $display("FAIL oor_rd got %b exp 00",
               {m1_waitrequest, mem_chipselect});
    else passed++;
    @(negedge clk);
    total++; if ({m1_readdatavalid, m1_err} !== 2'b11)
      $display("FAIL oor_rd_resp got %b exp 11",
               {m1_readdatavalid, m1_err});
    else passed++;
    total++; if (m1_readdata !== 32'h0)
      $display("FAIL oor_rd_data got %h exp 0", m1_readdata);
    else passed++;
    m1_address = 13'd4999;
    #1;
    total++; if (mem_chipselect !== 1'b1)
      $display("FAIL edge_cs got %b exp 1", mem_chipselect);
    else passed++;
    @(negedge clk);
    m1_read = 0;
    total++;
    if ({m1_readdatavalid, m1_err} !== 2'b10 ||
        m1_readdata !== gold[4999])
      $display("FAIL edge_rd got %b %h exp 10 %h",
               {m1_readdatavalid, m1_err}, m1_readdata, gold[4999]);
    else passed++;
    bus_idle();
  endtask

  task automatic test_byte_lanes();
    m0_write = 1; m0_address = 13'h020;
    m0_byteenable = 4'hF; m0_writedata = 32'h11223344;
    @(negedge clk);
    m0_byteenable = 4'b0010; m0_writedata = 32'hAABBCCDD;
    @(negedge clk);
    m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
    @(negedge clk);
    m0_read = 0;
    gold[32] = 32'h1122CC44;
    total++;
    if (!m0_readdatavalid || m0_readdata !== 32'h1122CC44)
      $display("FAIL be_merge got %b %h exp 1 1122cc44",
               m0_readdatavalid, m0_readdata);
    else passed++;
    bus_idle();
  endtask

  task automatic test_halt();
    int n;
    logic got;
    m0_read = 1; m0_address = 13'h010;
    #1;
    total++; if (m0_waitrequest !== 1'b0)
      $display("FAIL halt_pre got %b exp 0", m0_waitrequest);
    else passed++;
    @(negedge clk);
    halt_req = 1;
    m0_address = 13'h020;
    total++;
    if (!m0_readdatavalid || m0_readdata !== gold[16])
      $display("FAIL halt_inflight got %b %h exp 1 %h",
               m0_readdatavalid, m0_readdata, gold[16]);
    else passed++;
    #1;
    total++; if ({m0_waitrequest, mem_chipselect} !== 2'b10)
      $display("FAIL halt_nogrant got %b exp 10",
               {m0_waitrequest, mem_chipselect});
    else passed++;
    n = 0; got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (halt_ack === 1'b1) got = 1;
      else begin
        total++; if ({m0_waitrequest, mem_chipselect} !== 2'b10)
          $display("FAIL drain_wait got %b exp 10",
                   {m0_waitrequest, mem_chipselect});
        else passed++;
      end
    end
    total++; if (!got)
      $display("FAIL halt_ack_timeout got 0 exp 1");
    else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({halt_ack, mem_clken, mem_reset_req, m0_waitrequest,
           mem_chipselect, m0_readdatavalid} !== 6'b101100)
        $display("FAIL halted k=%0d got %b exp 101100", k,
                 {halt_ack, mem_clken, mem_reset_req,
                  m0_waitrequest, mem_chipselect, m0_readdatavalid});
      else passed++;
      if (k < 2) @(negedge clk);
    end
    halt_req = 0;
    #1;
    total++; if ({halt_ack, m0_waitrequest} !== 2'b11)
      $display("FAIL unhalt_same got %b exp 11",
               {halt_ack, m0_waitrequest});
    else passed++;
    @(negedge clk);
    total++;
    if ({halt_ack, mem_clken, mem_reset_req} !== 3'b010)
      $display("FAIL resume_ctl got %b exp 010",
               {halt_ack, mem_clken, mem_reset_req});
    else passed++;
    #1;
    total++;
    if ({m0_waitrequest, mem_chipselect} !== 2'b01 ||
        mem_address !== 13'h020)
      $display("FAIL resume_grant got %b %h exp 01 020",
               {m0_waitrequest, mem_chipselect}, mem_address);
    else passed++;
    @(negedge clk);
    m0_read = 0;
    total++;
    if (!m0_readdatavalid || m0_readdata !== gold[32])
      $display("FAIL resume_rd got %b %h exp 1 %h",
               m0_readdatavalid, m0_readdata, gold[32]);
    else passed++;
    bus_idle();
  endtask

  task automatic test_random();
    logic p0, p1, r0, r1, w0, w1;
    logic [12:0] a0, a1;
    logic [3:0] b0, b1;
    logic [31:0] d0, d1;
    logic ev0, ev1, ee0, ee1, ecs, ewr;
    logic [31:0] ed0, ed1;
    logic o;
    int win;
    int kind;
    p0 = 0; p1 = 0; r0 = 0; r1 = 0; w0 = 0; w1 = 0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 9) < 7) begin
        p0 = 1; kind = int'($urandom_range(0, 3));
        w0 = (kind == 1 || kind == 2);
        r0 = (kind != 1);
        a0 = pick_addr(); b0 = 4'($urandom); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 7) begin
        p1 = 1; kind = int'($urandom_range(0, 3));
        w1 = (kind == 1 || kind == 2);
        r1 = (kind != 1);
        a1 = pick_addr(); b1 = 4'($urandom); d1 = $urandom;
      end
      m0_read = p0 & r0; m0_write = p0 & w0;
      m0_address = a0; m0_byteenable = b0; m0_writedata = d0;
      m1_read = p1 & r1; m1_write = p1 & w1;
      m1_address = a1; m1_byteenable = b1; m1_writedata = d1;
      #1;
      win = -1;
      if (p0 && p1) win = pref;
      else if (p0) win = 0;
      else if (p1) win = 1;
      o = (win == 0) ? !in_range(a0) : !in_range(a1);
      ecs = (win >= 0) && !o;
      ewr = ecs && ((win == 0) ? w0 : w1);
      total++;
      if ({m0_waitrequest, m1_waitrequest} !==
          {p0 && win != 0, p1 && win != 1})
        $display("FAIL rnd_wait c=%0d got %b%b exp %b%b", c,
                 m0_waitrequest, m1_waitrequest,
                 p0 && win != 0, p1 && win != 1);
      else passed++;
      total++; if ({mem_chipselect, mem_write} !== {ecs, ewr})
        $display("FAIL rnd_cs c=%0d got %b%b exp %b%b", c,
                 mem_chipselect, mem_write, ecs, ewr);
      else passed++;
      ev0 = (win == 0) && !w0; ee0 = (win == 0) && o;
      ev1 = (win == 1) && !w1; ee1 = (win == 1) && o;
      ed0 = o ? 32'h0 : gold[a0];
      ed1 = o ? 32'h0 : gold[a1];
      if (win == 0 && w0 && !o) gold[a0] = merge(gold[a0], d0, b0);
      if (win == 1 && w1 && !o) gold[a1] = merge(gold[a1], d1, b1);
      if (p0 && p1) pref = (win == 0) ? 1 : 0;
      if (win == 0) p0 = 0;
      if (win == 1) p1 = 0;
      @(negedge clk);
      total++;
      if ({m0_readdatavalid, m0_err, m1_readdatavalid, m1_err} !==
          {ev0, ee0, ev1, ee1})
        $display("FAIL rnd_resp c=%0d got %b%b%b%b exp %b%b%b%b", c,
                 m0_readdatavalid, m0_err, m1_readdatavalid, m1_err,
                 ev0, ee0, ev1, ee1);
      else passed++;
      if (ev0) begin
        total++; if (m0_readdata !== ed0)
          $display("FAIL rnd_data0 c=%0d got %h exp %h",
                   c, m0_readdata, ed0);
        else passed++;
      end
      if (ev1) begin
        total++; if (m1_readdata !== ed1)
          $display("FAIL rnd_data1 c=%0d got %h exp %h",
                   c, m1_readdata, ed1);
        else passed++;
      end
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_rr_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    pref = 0;
    m0_read = 1; m1_read = 1;
    m0_address = 13'h041; m1_address = 13'h051;
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01)
      $display("FAIL rr_reset got %b exp 01",
               {m0_waitrequest, m1_waitrequest});
    else passed++;
    @(negedge clk);
    m0_read = 0;
    #1;
    total++; if ({m1_waitrequest, mem_address} !== {1'b0, 13'h051})
      $display("FAIL rr_solo got %b %h exp 0 051",
               m1_waitrequest, mem_address);
    else passed++;
    @(negedge clk);
    bus_idle();
    total++; if (m1_readdata !== gold[13'h051])
      $display("FAIL rr_solo_data got %h exp %h",
               m1_readdata, gold[13'h051]);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 32'(i) * 32'h9E3779B1;
      gold[i] = 32'(i) * 32'h9E3779B1;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_byte_lanes();
    test_halt();
    test_random();
    test_rr_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
